// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared constants and helpers for the PWM peripheral.
//                Holds timebase width, terminal count, the "full duty" code
//                and the channel count, plus the PWM level compare used by
//                the top level.
//  Revision    : 1.0  initial release
// ============================================================================
package pwm_pkg;

    // Width of the shared PWM timebase counter
    localparam int              PWM_CNT_W   = 8;

    // Last count of the timebase before it rolls over to zero
    localparam logic [PWM_CNT_W-1:0] PWM_CNT_MAX = 8'hFF;

    // Duty code that means "always high" (no low cycle at any count)
    localparam logic [PWM_CNT_W-1:0] DUTY_FULL   = 8'hFF;

    // Number of output pins driven by the peripheral
    localparam int              NUM_CH      = 16;

    // PWM level for a given timebase count and latched duty.
    // A plain (cnt < duty) compare can never reach 100 %, because cnt
    // reaches 255 and 255 < 255 is false; the full-scale code is therefore
    // special-cased so that it stays high for the whole period.
    function automatic logic pwm_level(
        input logic [PWM_CNT_W-1:0] cnt,
        input logic [PWM_CNT_W-1:0] duty
    );
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_timebase
//  Description : Shared PWM timebase. A prescaler divides clk by PRESCALE
//                to produce a counter tick; an 8-bit counter advances on
//                each tick and rolls over 255 -> 0. Flags the roll-over
//                cycle (wrap, combinational) and the first cycle of each new
//                period (period_start, registered).
//  Ports       : clk           in   system clock
//                rst_n         in   asynchronous active-low reset
//                pwm_cnt       out  current timebase count (registered)
//                wrap          out  high in the cycle the counter rolls over
//                period_start  out  one-cycle pulse when pwm_cnt becomes 0
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_timebase
    import pwm_pkg::*;
#(
    // clk cycles per timebase tick; legal values are 1 and above
    parameter int PRESCALE = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PWM_CNT_W-1:0] pwm_cnt,
    output logic                 wrap,
    output logic                 period_start
);

    logic                 w_tick;
    logic                 w_wrap;
    logic [PWM_CNT_W-1:0] r_pwm_cnt;
    logic                 r_period_start;

    // ------------------------------------------------------------------
    // Prescaler. With PRESCALE == 1 there is nothing to count: every
    // cycle is a tick, and no prescaler register is built.
    // ------------------------------------------------------------------
    generate
        if (PRESCALE == 1) begin : g_no_presc
            assign w_tick = 1'b1;
        end else begin : g_presc
            localparam int                  C_PRESC_W    = $clog2(PRESCALE);
            localparam logic [C_PRESC_W-1:0] C_PRESC_LAST = C_PRESC_W'(PRESCALE - 1);

            logic [C_PRESC_W-1:0] r_presc_cnt;

            assign w_tick = (r_presc_cnt == C_PRESC_LAST);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_presc_cnt <= '0;
                end else if (w_tick) begin
                    r_presc_cnt <= '0;
                end else begin
                    r_presc_cnt <= r_presc_cnt + 1'b1;
                end
            end
        end
    endgenerate

    // Roll-over happens on the tick that leaves the terminal count
    assign w_wrap = w_tick && (r_pwm_cnt == PWM_CNT_MAX);

    // ------------------------------------------------------------------
    // Timebase counter and period-start flag. period_start is the
    // registered copy of wrap, so it is high exactly while the counter
    // sits on its first zero of a new period. It never fires out of
    // reset because no wrap has happened yet.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt      <= '0;
            r_period_start <= 1'b0;
        end else begin
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 1'b1;   // 8-bit, wraps 255 -> 0
            end
            r_period_start <= w_wrap;
        end
    end

    assign pwm_cnt      = r_pwm_cnt;
    assign wrap         = w_wrap;
    assign period_start = r_period_start;

endmodule : pwm_timebase
`default_nettype wire

// File: rtl/pwm_peripheral.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_peripheral
//  Description : Drives 16 output pins from the SPI control registers.
//                Each pin is off, statically on, or follows one shared PWM
//                waveform. The duty code is shadowed at each period
//                boundary so a mid-period write never produces a glitch.
//  Ports       : clk              in   system clock (10 MHz)
//                rst_n            in   asynchronous active-low reset
//                en_reg_out_7_0   in   output enable, channels 7:0
//                en_reg_out_15_8  in   output enable, channels 15:8
//                en_reg_pwm_7_0   in   PWM mode select, channels 7:0
//                en_reg_pwm_15_8  in   PWM mode select, channels 15:8
//                pwm_duty_cycle   in   requested duty 0x00..0xFF
//                out              out  registered output pins
//                pwm_cnt          out  current timebase count
//                period_start     out  one-cycle pulse at each new period
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_peripheral
    import pwm_pkg::*;
#(
    // clk cycles per timebase tick; 13 gives ~3.0 kHz from 10 MHz
    parameter int PRESCALE = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           en_reg_out_7_0,
    input  logic [7:0]           en_reg_out_15_8,
    input  logic [7:0]           en_reg_pwm_7_0,
    input  logic [7:0]           en_reg_pwm_15_8,
    input  logic [PWM_CNT_W-1:0] pwm_duty_cycle,
    output logic [NUM_CH-1:0]    out,
    output logic [PWM_CNT_W-1:0] pwm_cnt,
    output logic                 period_start
);

    logic [PWM_CNT_W-1:0] w_pwm_cnt;
    logic                 w_wrap;
    logic [PWM_CNT_W-1:0] r_duty_shadow;
    logic                 w_pwm_lvl;
    logic [NUM_CH-1:0]    w_en_out;
    logic [NUM_CH-1:0]    w_en_pwm;
    logic [NUM_CH-1:0]    w_out_nxt;
    logic [NUM_CH-1:0]    r_out;

    // ------------------------------------------------------------------
    // Shared timebase
    // ------------------------------------------------------------------
    pwm_timebase #(
        .PRESCALE     (PRESCALE)
    ) u_timebase (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_cnt      (w_pwm_cnt),
        .wrap         (w_wrap),
        .period_start (period_start)
    );

    // ------------------------------------------------------------------
    // Duty shadow. Loaded only on the roll-over cycle, so the new value
    // and the new period (count 0) take effect together. A duty write
    // landing in the roll-over cycle itself is captured.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_shadow <= '0;
        end else if (w_wrap) begin
            r_duty_shadow <= pwm_duty_cycle;
        end
    end

    assign w_pwm_lvl = pwm_level(w_pwm_cnt, r_duty_shadow);

    // ------------------------------------------------------------------
    // Per-channel output select. Enables act immediately (one register
    // stage), independent of where the timebase is in its period.
    // ------------------------------------------------------------------
    assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign w_out_nxt[i] = w_en_out[i] ? (w_en_pwm[i] ? w_pwm_lvl : 1'b1) : 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_out_nxt;
        end
    end

    assign out     = r_out;
    assign pwm_cnt = w_pwm_cnt;

endmodule : pwm_peripheral
`default_nettype wire

// File: tb/tb_pwm_peripheral.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_peripheral
//  Description : Self-checking bench for pwm_peripheral. Two instances
//                (PRESCALE 1 and 2) share stimulus; a cycle-count based
//                reference model predicts out, pwm_cnt and period_start for
//                both on every clock. A vector table covers static enables,
//                hand sequences cover duty extremes, shadowing, the wrap
//                tie-break, mixed modes and async reset, and a randomized
//                phase closes out the run.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pwm_peripheral;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;

    logic [15:0] out1, out2;
    logic [7:0]  cnt1, cnt2;
    logic        ps1, ps2;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: clk edges since reset release, and the duty
    // value latched for the current period of each instance.
    int          k;
    logic [7:0]  sh1, sh2;

    typedef struct {
        logic [15:0] en_out;
        logic [15:0] en_pwm;
        logic [7:0]  duty;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    pwm_peripheral #(.PRESCALE(1)) u_dut_p1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out1),
        .pwm_cnt         (cnt1),
        .period_start    (ps1)
    );

    pwm_peripheral #(.PRESCALE(2)) u_dut_p2 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out2),
        .pwm_cnt         (cnt2),
        .period_start    (ps2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (k=%0d)", name, act, exp, k);
        end
    endtask

    // Expected pin word given an instance's count and latched duty
    function automatic logic [15:0] exp_pins(input int cnt, input logic [7:0] sh);
        logic lvl;
        lvl = (sh == 8'hFF) ? 1'b1 : (cnt < int'(sh));
        return en_out & (~en_pwm | {16{lvl}});
    endfunction

    // One clock: predict from pre-edge state, advance, compare after edge
    task automatic step();
        logic [15:0] e1, e2;
        e1 = exp_pins((k / 1) % 256, sh1);
        e2 = exp_pins((k / 2) % 256, sh2);
        @(posedge clk);
        k++;
        if (k % 256 == 0) sh1 = duty;
        if (k % 512 == 0) sh2 = duty;
        #1;
        chk("out_p1", 32'(out1), 32'(e1));
        chk("cnt_p1", 32'(cnt1), 32'((k / 1) % 256));
        chk("ps_p1",  32'(ps1),  32'(k % 256 == 0));
        chk("out_p2", 32'(out2), 32'(e2));
        chk("cnt_p2", 32'(cnt2), 32'((k / 2) % 256));
        chk("ps_p2",  32'(ps2),  32'(k % 512 == 0));
    endtask

    // Step until the PRESCALE=1 instance shows period_start (bounded)
    task automatic wait_ps();
        for (int j = 0; j < 600 && !ps1; j++) step();
        chk("wait_period_start", 32'(ps1), 32'd1);
    endtask

    // 256 clocks from one period_start of instance 1 to the next; counts
    // high cycles of a few representative pins. Optionally rewrites duty
    // after step chg_at.
    task automatic run_period(input int chg_at, input logic [7:0] nd,
                              output int hi0, output int hi4, output int hi8, output int nps);
        hi0 = 0; hi4 = 0; hi8 = 0; nps = 0;
        for (int j = 1; j <= 256; j++) begin
            step();
            hi0 += int'(out1[0]);
            hi4 += int'(out1[4]);
            hi8 += int'(out1[8]);
            nps += int'(ps1);
            if (j == chg_at) duty = nd;
        end
        chk("period_end_ps", 32'(ps1), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_p1"}, 32'(out1), 32'd0);
        chk({tag, "_cnt_p1"}, 32'(cnt1), 32'd0);
        chk({tag, "_ps_p1"},  32'(ps1),  32'd0);
        chk({tag, "_out_p2"}, 32'(out2), 32'd0);
        chk({tag, "_cnt_p2"}, 32'(cnt2), 32'd0);
        chk({tag, "_ps_p2"},  32'(ps2),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int h0, h4, h8, np;

        vecs[0] = '{16'h0001, 16'h0000, 8'h00, 16'h0001};
        vecs[1] = '{16'h8000, 16'h0000, 8'h00, 16'h8000};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 8'h00, 16'h0000};  // first period: duty 0
        vecs[3] = '{16'h00FF, 16'h000F, 8'h00, 16'h00F0};
        vecs[4] = '{16'hFFFF, 16'h0000, 8'h55, 16'hFFFF};

        rst_n  = 1'b0;
        en_out = '0;
        en_pwm = '0;
        duty   = '0;
        k      = 0;
        sh1    = '0;
        sh2    = '0;

        #2;
        check_reset_values("por");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Static enables and the first (duty 0) period
        for (int v = 0; v < 5; v++) begin
            en_out = vecs[v].en_out;
            en_pwm = vecs[v].en_pwm;
            duty   = vecs[v].duty;
            step();
            chk($sformatf("tbl%0d_p1", v), 32'(out1), 32'(vecs[v].exp_out));
            chk($sformatf("tbl%0d_p2", v), 32'(out2), 32'(vecs[v].exp_out));
        end

        // 50 % duty, all channels in PWM mode
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        duty   = 8'h80;
        wait_ps();
        run_period(0, 8'h00, h0, h4, h8, np);
        chk("duty80_high", 32'(h0), 32'd128);
        chk("duty80_ps_count", 32'(np), 32'd1);

        // Duty 0x00: never high
        duty = 8'h00;
        run_period(0, 8'h00, h0, h4, h8, np);
        run_period(0, 8'h00, h0, h4, h8, np);
        chk("duty00_high", 32'(h0), 32'd0);

        // Duty 0xFF: high for two full periods including the wrap between
        duty = 8'hFF;
        run_period(0, 8'h00, h0, h4, h8, np);
        run_period(0, 8'h00, h0, h4, h8, np);
        chk("dutyFF_high_a", 32'(h0), 32'd256);
        run_period(0, 8'h00, h0, h4, h8, np);
        chk("dutyFF_high_b", 32'(h0), 32'd256);

        // Shadowing: change 0x40 -> 0xC0 at count 100
        duty = 8'h40;
        run_period(0, 8'h00, h0, h4, h8, np);
        run_period(100, 8'hC0, h0, h4, h8, np);
        chk("shadow_cur", 32'(h0), 32'd64);
        run_period(0, 8'h00, h0, h4, h8, np);
        chk("shadow_next", 32'(h0), 32'd192);

        // Tie-break: write lands in the wrap cycle and is captured
        run_period(255, 8'h20, h0, h4, h8, np);
        chk("tie_cur", 32'(h0), 32'd192);
        run_period(0, 8'h00, h0, h4, h8, np);
        chk("tie_next", 32'(h0), 32'd32);

        // Mixed modes
        en_out = 16'h00FF;
        en_pwm = 16'h000F;
        duty   = 8'h10;
        run_period(0, 8'h00, h0, h4, h8, np);
        run_period(0, 8'h00, h0, h4, h8, np);
        chk("mixed_pwm_bit", 32'(h0), 32'd16);
        chk("mixed_const1",  32'(h4), 32'd256);
        chk("mixed_const0",  32'(h8), 32'd0);

        // Async reset mid-period with outputs active
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        duty   = 8'h80;
        run_period(0, 8'h00, h0, h4, h8, np);
        repeat (50) step();
        chk("pre_reset_active", 32'(out1), 32'h0000FFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_async");
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        k   = 0;
        sh1 = '0;
        sh2 = '0;
        step();
        step();
        chk("rst_release_cnt_p2", 32'(cnt2), 32'd1);
        chk("rst_release_cnt_p1", 32'(cnt1), 32'd2);

        // Randomized phase: sporadic register writes at arbitrary points
        for (int j = 0; j < 3000; j++) begin
            step();
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 4))
                    0: en_out = 16'($urandom);
                    1: en_pwm = 16'($urandom);
                    2: duty   = 8'($urandom);
                    3: duty   = 8'h00;
                    default: duty = 8'hFF;
                endcase
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_pwm_peripheral
`default_nettype wire

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
Downstream consumer of the SPI register block. Takes the five 8-bit control registers (output enables, PWM enables, duty cycle) and drives 16 output pins. A shared prescaled 8-bit timebase generates one PWM waveform. Duty is shadowed at period boundaries so waveforms are glitch-free. Runs on the 10 MHz system clock; the default PWM frequency is approximately 3 kHz.

Parameters:
PRESCALE, 13, clk cycles per PWM counter tick; legal range >=1; 10 MHz/(13*256) = 3.0 kHz
NUM_CH, 16, output channel count; fixed at 16 for this revision

Ports:
clk  input  1  system clock, 10 MHz
rst_n  input  1  reset
en_reg_out_7_0  input  8  output enable, channels 7:0
en_reg_out_15_8  input  8  output enable, channels 15:8
en_reg_pwm_7_0  input  8  PWM mode select, channels 7:0
en_reg_pwm_15_8  input  8  PWM mode select, channels 15:8
pwm_duty_cycle  input  8  requested duty, 0x00..0xFF
out  output  16  registered output pins
pwm_cnt  output  8  current timebase count, for observability and test
period_start  output  1  one-cycle pulse when pwm_cnt becomes 0

Behaviour:
- Clock and reset: clock clk; reset rst_n, asynchronous, active-low.
- Reset values: out=16'h0000, pwm_cnt=0, period_start=0, prescaler count=0, duty_shadow=0.
- Inputs: quasi-static, same clock domain; no synchronisation required.
- Prescaler: presc_cnt counts 0..PRESCALE-1.
  - tick=1 in the cycle where presc_cnt==PRESCALE-1; presc_cnt then returns to 0.
  - PRESCALE=1: tick=1 every cycle.
- Timebase: on tick, pwm_cnt <= pwm_cnt+1, modulo 256 (255 -> 0).
  - Period = 256*PRESCALE clk cycles.
- wrap = tick && pwm_cnt==255.
- Duty shadow: on wrap, duty_shadow <= pwm_duty_cycle.
  - Writes to pwm_duty_cycle mid-period do not affect the current period.
  - First period after reset runs with duty_shadow=0.
- Duty tie-break: pwm_duty_cycle changing in the same cycle as wrap captures the new value.
- PWM level:
  - pwm_lvl = 1 if duty_shadow==8'hFF (100%, no low glitch).
  - Otherwise pwm_lvl = (pwm_cnt < duty_shadow).
  - High time per period = duty_shadow*PRESCALE cycles, except 0xFF gives always high.
  - duty 0x00 gives always low.
- Per channel i, registered each clk:
  - out[i] <= en_out[i] ? (en_pwm[i] ? pwm_lvl : 1'b1) : 1'b0
  - en_out = {en_reg_out_15_8, en_reg_out_7_0}; en_pwm likewise.
- Latency:
  - Enable/mode register change appears on out exactly 1 clk later; not period-aligned.
  - out reflects the pwm_cnt/duty_shadow values from the previous cycle.
- period_start: registered; high for exactly one clk, the first cycle where pwm_cnt==0 after a wrap. Not asserted out of reset.
- Reset mid-period: all state returns to reset values immediately (async); counting resumes from 0 on the first clk after deassertion.
- All channels share one timebase; PWM channels are phase-aligned (rise together at pwm_cnt==0).

Decomposition:
- Package pwm_pkg:
  - PWM_CNT_W=8
  - PWM_CNT_MAX=8'hFF
  - DUTY_FULL=8'hFF
  - NUM_CH=16
- Sub-module pwm_timebase: prescaler, pwm_cnt, wrap, period_start. Parameter PRESCALE; outputs pwm_cnt, wrap, period_start.
- Top level: duty shadow, level compare, per-channel output mux/registers.

Test Plan:
1. Reset: assert rst_n=0 mid-period with out active -> out=0, pwm_cnt=0, period_start=0 immediately; after release with PRESCALE=2, pwm_cnt=1 after 2 clks.
2. Static enable: en_out=16'h0001, en_pwm=0 -> out=16'h0001 exactly 1 clk later; en_out=16'h8000 -> out=16'h8000 next clk.
3. Duty 50%: PRESCALE=1, en_out=en_pwm=16'hFFFF, duty=0x80 -> after first wrap, every out bit high 128 clks then low 128 clks per 256-clk period; period_start pulses every 256 clks.
4. Extremes: duty=0x00 -> out=0 for a full period; duty=0xFF -> out=16'hFFFF continuously, no low cycle across wrap.
5. Shadowing: duty=0x40 active, change to 0xC0 at pwm_cnt=100 -> current period high 64 ticks; next period high 192 ticks.
6. Mixed modes: en_out=16'h00FF, en_pwm=16'h000F, duty=0x10 -> bits 3:0 PWM at 16/256, bits 7:4 constant 1, bits 15:8 constant 0.
